// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
// Multiplexed 7-segment scan controller: latches a hex value, time-multiplexes one
// digit at a time onto a shared nibble bus and drives active-low anodes with dead time.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // load is a single-cycle strobe with no backpressure: data/dp are captured on any edge where it is high
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lzs,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     an,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dpr_q, dpr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                primed_q, primed_d;

  logic [3:0]          nibble_q, nibble_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                dp_n_q, dp_n_d;
  logic                frame_tick_q, frame_tick_d;

  logic                blank_sel, dp_sel, sup_sel, zero_run, active;

  // The first edge after reset holds cnt/idx so the output registers present cnt=0, idx=0.
  always_comb begin
    val_d    = val_q;
    dpr_d    = dpr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    primed_d = 1'b1;
    if (load) begin
      val_d = data;
      dpr_d = dp;
    end
    if (primed_q) begin
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Outputs are decoded from next-state values so the registered outputs line up with idx/cnt.
  always_comb begin
    nibble_d  = 4'h0;
    blank_sel = 1'b0;
    dp_sel    = 1'b0;
    sup_sel   = 1'b0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (val_d[4*i +: 4] == 4'h0);
      if (idx_d == IDX_W'(i)) begin
        nibble_d  = val_d[4*i +: 4];
        blank_sel = blank_mask[i];
        dp_sel    = dpr_d[i];
        sup_sel   = lzs && (i != 0) && zero_run;
      end
    end
    active = (cnt_d >= CNT_W'(DEAD_CYCLES)) && !blank_sel && !sup_sel;
    an_d   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (active && (idx_d == IDX_W'(i))) an_d[i] = 1'b0;
    end
    dp_n_d       = ~(active && dp_sel);
    frame_tick_d = (idx_d == '0) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q        <= '0;
      dpr_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      primed_q     <= 1'b0;
      nibble_q     <= 4'h0;
      an_q         <= '1;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      val_q        <= val_d;
      dpr_q        <= dpr_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      primed_q     <= primed_d;
      nibble_q     <= nibble_d;
      an_q         <= an_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign nibble     = nibble_q;
  assign an         = an_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
// Scoreboard bench for seg7_scan_driver: a cycle-indexed reference model predicts every
// output cycle, and a negedge monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int D    = 4;
  localparam int RD   = 8;
  localparam int DEAD = 1;
  localparam int W    = D + 4 + 2;
  localparam logic [W-1:0] RST_VAL = {4'b1111, 4'h0, 1'b1, 1'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [4*D-1:0] data;
  logic [D-1:0]  dp;
  logic [D-1:0]  blank_mask;
  logic          lzs;
  logic [3:0]    nibble;
  logic [D-1:0]  an;
  logic          dp_n;
  logic          frame_tick;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           m_t;
  logic [15:0]  m_val;
  logic [3:0]   m_dpr;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .blank_mask (blank_mask),
    .lzs        (lzs),
    .nibble     (nibble),
    .an         (an),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Expected outputs for the t-th cycle after reset release.
  function automatic logic [W-1:0] expect_out(int t, logic [15:0] v, logic [3:0] d,
                                              logic [3:0] m, logic z);
    int          slot, idx, cnt;
    logic [15:0] sh;
    logic        sup, act;
    logic [3:0]  a;
    slot = t / RD;
    idx  = slot % D;
    cnt  = t % RD;
    sh   = v >> (4 * idx);
    sup  = z && (idx > 0) && (sh == 16'h0);
    act  = (cnt >= DEAD) && !m[idx] && !sup;
    a    = 4'hF;
    if (act) a[idx] = 1'b0;
    return {a, sh[3:0], ~(act && d[idx]), ((t % (D * RD)) == 0)};
  endfunction

  task automatic check(string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got an=%b nib=%h dp_n=%b ft=%b exp an=%b nib=%h dp_n=%b ft=%b",
               name, m_t, got[9:6], got[5:2], got[1], got[0],
               exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Reference model: one expected entry per clock edge out of reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_t   = 0;
      m_val = '0;
      m_dpr = '0;
    end else begin
      if (load) begin
        m_val = data;
        m_dpr = dp;
      end
      exp_q.push_back(expect_out(m_t, m_val, m_dpr, blank_mask, lzs));
      m_t++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      check("reset_hold", {an, nibble, dp_n, frame_tick}, RST_VAL);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scan", {an, nibble, dp_n, frame_tick}, e);
    end
  end

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_value(logic [15:0] v, logic [3:0] d);
    load = 1'b1;
    data = v;
    dp   = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Waits (bounded) until the cycle currently on the outputs is position c within a frame.
  task automatic wait_cycle(int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((((m_t - 1) % (D * RD)) != c) && (n < 4 * D * RD));
    checks++;
    if (((m_t - 1) % (D * RD)) != c) begin
      failures++;
      $display("FAIL wait_cycle got=%0d exp=%0d", (m_t - 1) % (D * RD), c);
    end
  endtask

  task automatic async_reset(int dly);
    @(posedge clk);
    #(dly) rst = 1'b1;
    #1 check("async_reset", {an, nibble, dp_n, frame_tick}, RST_VAL);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    rst = 1'b1; load = 1'b0; data = '0; dp = '0; blank_mask = '0; lzs = 1'b0;
    run(2);
    rst = 1'b0;

    load_value(16'h1234, 4'h0);
    run(40);

    wait_cycle(10);
    async_reset(2);
    run(34);

    lzs = 1'b1;
    load_value(16'h0070, 4'h0);
    run(34);
    load_value(16'h0000, 4'h0);
    run(34);

    lzs = 1'b0;
    blank_mask = 4'b0100;
    load_value(16'h1234, 4'b0011);
    run(34);

    blank_mask = 4'b0000;
    wait_cycle(12);
    load_value(16'hABCD, 4'h0);
    run(40);

    wait_cycle(18);
    async_reset(3);
    run(34);

    for (int n = 0; n < 900; n++) begin
      load = ($urandom_range(0, 5) == 0);
      if (load) begin
        for (int k = 0; k < 4; k++)
          rd[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        data = rd;
        dp   = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) lzs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) async_reset(int'($urandom_range(1, 4)));
      else @(negedge clk);
    end
    load = 1'b0;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
